conv_tile_scheduler: RTL

Sequencer for the tiled convolution array: the TOTSUBIMAGEM×TOTSUBIMAGEM grid of per-tile kernel engines that process all sub-images in lockstep. On `start` it walks the shared window origin (row, col) across every valid kernel position inside one tile. For each position it issues one-cycle load, multi-cycle compute and backpressured write-back strobes, then pulses `done`. It replaces the free-running three-state loop with an explicit, abortable handshake controller that sits between the layer-level control and the tile array.

---
 rtl/conv_tile_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/conv_tile_scheduler.sv
// Window-origin sequencer for the tiled convolution array: walks every valid kernel
// position inside a tile and issues load / compute / backpressured write-back strobes.
module conv_tile_scheduler #(
  parameter int SIZE         = 320,
  parameter int SIZEKer      = 3,
  parameter int TOTSUBIMAGEM = 16,
  parameter int WIDTH_BIT    = 16,
  parameter int CONV_LAT     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 wb_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 load_en,
  output logic                 conv_en,
  output logic                 wb_en,
  output logic                 wb_last,
  output logic [WIDTH_BIT-1:0] win_row,
  output logic [WIDTH_BIT-1:0] win_col
);

  localparam int TILE = SIZE / TOTSUBIMAGEM;
  localparam int NPOS = TILE - SIZEKer + 1;
  localparam int CW   = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [WIDTH_BIT-1:0] LAST = WIDTH_BIT'(NPOS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WB, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH_BIT-1:0] row_reg, row_next;
  logic [WIDTH_BIT-1:0] col_reg, col_next;
  logic busy_next, done_next, load_en_next, conv_en_next, wb_en_next, wb_last_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_en   <= 1'b0;
      conv_en   <= 1'b0;
      wb_en     <= 1'b0;
      wb_last   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      busy      <= busy_next;
      done      <= done_next;
      load_en   <= load_en_next;
      conv_en   <= conv_en_next;
      wb_en     <= wb_en_next;
      wb_last   <= wb_last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          row_next   = '0;
          col_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next   = CW'(CONV_LAT - 1);
        state_next = COMPUTE;
      end
      COMPUTE: begin
        if (cnt_reg == '0) state_next = WB;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      WB: begin
        if (wb_ready) begin
          if (row_reg == LAST && col_reg == LAST) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
            if (col_reg == LAST) begin
              col_next = '0;
              row_next = row_reg + WIDTH_BIT'(1);
            end else begin
              col_next = col_reg + WIDTH_BIT'(1);
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort beats any same-cycle write-back handshake and discards the origin.
    if (abort && (state_reg == LOAD || state_reg == COMPUTE || state_reg == WB)) begin
      state_next = IDLE;
      row_next   = '0;
      col_next   = '0;
    end
  end

  // Strobes are decoded from the upcoming state so they appear registered.
  always_comb begin
    busy_next    = (state_next == LOAD) || (state_next == COMPUTE) || (state_next == WB);
    done_next    = (state_next == DONE);
    load_en_next = (state_next == LOAD);
    conv_en_next = (state_next == COMPUTE);
    wb_en_next   = (state_next == WB);
    wb_last_next = (state_next == WB) && (row_next == LAST) && (col_next == LAST);
  end

  assign win_row = row_reg;
  assign win_col = col_reg;

endmodule
